// File: rtl/push_event_pkg.sv
// Shared state encoding and 50 MHz timing defaults for the push-button conditioner.
package push_event_pkg;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_DB_PRESS = 3'd1;
  localparam logic [2:0] S_HOLD     = 3'd2;
  localparam logic [2:0] S_REPEAT   = 3'd3;
  localparam logic [2:0] S_DB_REL   = 3'd4;

  localparam int DB_CYC_DEF      = 500000;
  localparam int RPT_DLY_CYC_DEF = 25000000;
  localparam int RPT_PER_CYC_DEF = 5000000;

  // One counter per channel is shared by all timing phases, so size it for the longest.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/push_chan.sv
// One button channel: 2-flop synchronizer, press/release debounce, press and auto-repeat pulses.
//   state      | meaning
//   S_IDLE     | released, waiting for a low sample
//   S_DB_PRESS | low seen, counting the press stability window
//   S_HOLD     | pressed, counting the delay to the first repeat
//   S_REPEAT   | pressed, emitting a pulse every repeat period
//   S_DB_REL   | high seen while pressed, counting the release window
module push_chan
  import push_event_pkg::*;
#(
  parameter int DB_CYC      = DB_CYC_DEF,
  parameter int RPT_DLY_CYC = RPT_DLY_CYC_DEF,
  parameter int RPT_PER_CYC = RPT_PER_CYC_DEF,
  parameter int RPT_EN      = 1
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_Push,
  output logic o_Pulse,
  output logic o_Level
);

  localparam int CNT_W = cnt_width(DB_CYC, RPT_DLY_CYC, RPT_PER_CYC);
  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DB_CYC - 1);
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(RPT_DLY_CYC - 1);
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(RPT_PER_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic             r_sync_meta;
  logic             r_sync;
  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pulse;
  logic             r_level;

  logic [2:0]       w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_pulse_nxt;

  assign w_cnt_inc = r_cnt + CNT_W'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pulse_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!r_sync) begin
          w_state_nxt = S_DB_PRESS;
          w_cnt_nxt   = '0;
        end
      end
      S_DB_PRESS: begin
        if (r_sync) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == DB_LAST) begin
          w_state_nxt = S_HOLD;
          w_pulse_nxt = 1'b1;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      S_HOLD: begin
        if (r_sync) begin
          w_state_nxt = S_DB_REL;
          w_cnt_nxt   = '0;
        end else if ((RPT_EN != 0) && (r_cnt == DLY_LAST)) begin
          w_state_nxt = S_REPEAT;
          w_pulse_nxt = 1'b1;
          w_cnt_nxt   = '0;
        end else if (r_cnt != CNT_MAX) begin
          // saturating keeps a long hold without repeat from wrapping
          w_cnt_nxt = w_cnt_inc;
        end
      end
      S_REPEAT: begin
        if (r_sync) begin
          w_state_nxt = S_DB_REL;
          w_cnt_nxt   = '0;
        end else if (r_cnt == PER_LAST) begin
          w_pulse_nxt = 1'b1;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      S_DB_REL: begin
        if (!r_sync) begin
          w_state_nxt = S_HOLD;
          w_cnt_nxt   = '0;
        end else if (r_cnt == DB_LAST) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      r_sync_meta <= 1'b1;
      r_sync      <= 1'b1;
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_pulse     <= 1'b0;
      r_level     <= 1'b0;
    end else begin
      r_sync_meta <= i_Push;
      r_sync      <= r_sync_meta;
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_pulse     <= w_pulse_nxt;
      r_level     <= (w_state_nxt == S_HOLD) || (w_state_nxt == S_REPEAT) ||
                     (w_state_nxt == S_DB_REL);
    end
  end

  assign o_Pulse = r_pulse;
  assign o_Level = r_level;

endmodule

// File: rtl/push_event_gen.sv
// Active-low push-button conditioner: N_BTN independent debounced press/repeat channels.
module push_event_gen
  import push_event_pkg::*;
#(
  parameter int N_BTN       = 2,
  parameter int DB_CYC      = DB_CYC_DEF,
  parameter int RPT_DLY_CYC = RPT_DLY_CYC_DEF,
  parameter int RPT_PER_CYC = RPT_PER_CYC_DEF,
  parameter int RPT_EN      = 1
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic [N_BTN-1:0] i_Push,
  output logic [N_BTN-1:0] o_Pulse,
  output logic [N_BTN-1:0] o_Level
);

  for (genvar g = 0; g < N_BTN; g++) begin : g_chan
    push_chan #(
      .DB_CYC      (DB_CYC),
      .RPT_DLY_CYC (RPT_DLY_CYC),
      .RPT_PER_CYC (RPT_PER_CYC),
      .RPT_EN      (RPT_EN)
    ) u_chan (
      .i_Clk   (i_Clk),
      .i_Rst   (i_Rst),
      .i_Push  (i_Push[g]),
      .o_Pulse (o_Pulse[g]),
      .o_Level (o_Level[g])
    );
  end

endmodule

// File: tb/tb_push_event_gen.sv
// Bench for push_event_gen: vector table, directed corner sequences and a random run against a run-length model.
module tb_push_event_gen;

  localparam int DB  = 4;
  localparam int DLY = 20;
  localparam int PER = 8;

  logic       clk;
  logic       rst_n;
  logic [1:0] push;
  logic [1:0] pulse_a, level_a;
  logic [1:0] pulse_b, level_b;

  int n_checks;
  int n_pass;

  push_event_gen #(.N_BTN(2), .DB_CYC(DB), .RPT_DLY_CYC(DLY), .RPT_PER_CYC(PER), .RPT_EN(1)) u_dut_rpt (
    .i_Clk(clk), .i_Rst(rst_n), .i_Push(push), .o_Pulse(pulse_a), .o_Level(level_a));

  push_event_gen #(.N_BTN(2), .DB_CYC(DB), .RPT_DLY_CYC(DLY), .RPT_PER_CYC(PER), .RPT_EN(0)) u_dut_single (
    .i_Clk(clk), .i_Rst(rst_n), .i_Push(push), .o_Pulse(pulse_b), .o_Level(level_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: index [0] = repeating instance, [1] = single-pulse instance.
  bit         m_q1   [2][2];
  bit         m_q2   [2][2];
  bit         m_lvl  [2][2];
  int         m_low  [2][2];
  int         m_high [2][2];
  int         m_n    [2][2];
  logic [1:0] m_pulse[2];
  logic [1:0] m_level[2];

  task automatic check2(input string name, input logic [1:0] act, input logic [1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < 2; c++) begin
        m_q1[d][c] = 1'b1; m_q2[d][c] = 1'b1; m_lvl[d][c] = 1'b0;
        m_low[d][c] = 0; m_high[d][c] = 0; m_n[d][c] = 0;
      end
      m_pulse[d] = 2'b00;
      m_level[d] = 2'b00;
    end
  endtask

  // Expressed as consecutive-sample run lengths seen after the 2-sample input delay.
  task automatic model_edge();
    bit seen;
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < 2; c++) begin
        seen = m_q2[d][c];
        m_q2[d][c] = m_q1[d][c];
        m_q1[d][c] = push[c];
        m_pulse[d][c] = 1'b0;
        if (!m_lvl[d][c]) begin
          if (!seen) begin
            m_low[d][c]++;
            if (m_low[d][c] == DB + 1) begin
              m_lvl[d][c] = 1'b1; m_pulse[d][c] = 1'b1;
              m_n[d][c] = 0; m_high[d][c] = 0;
            end
          end else begin
            m_low[d][c] = 0;
          end
        end else begin
          if (seen) begin
            m_high[d][c]++;
            if (m_high[d][c] == DB + 1) begin
              m_lvl[d][c] = 1'b0; m_low[d][c] = 0;
            end
          end else if (m_high[d][c] > 0) begin
            m_high[d][c] = 0; m_n[d][c] = 0;
          end else begin
            m_n[d][c]++;
            if (d == 0 && m_n[d][c] >= DLY && ((m_n[d][c] - DLY) % PER) == 0)
              m_pulse[d][c] = 1'b1;
          end
        end
        m_level[d][c] = m_lvl[d][c];
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check2("model_pulse_rpt", pulse_a, m_pulse[0]);
    check2("model_level_rpt", level_a, m_level[0]);
    check2("model_pulse_single", pulse_b, m_pulse[1]);
    check2("model_level_single", level_b, m_level[1]);
  endtask

  typedef struct {
    logic [1:0] push;
    int         n_edges;
    logic [1:0] pulse_a;
    logic [1:0] level_a;
    logic [1:0] pulse_b;
    logic [1:0] level_b;
  } vec_t;

  vec_t vq[$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  e;
    bit  got;
    int  cnt_a, cnt_b, first_b;
    bit  seen_p, seen_l, lvl_drop;
    bit  val[2];
    int  left[2];

    n_checks = 0;
    n_pass   = 0;
    push  = 2'b11;
    rst_n = 1'b0;
    model_reset();
    #1;
    check2("reset_pulse_rpt", pulse_a, 2'b00);
    check2("reset_level_rpt", level_a, 2'b00);
    check2("reset_pulse_single", pulse_b, 2'b00);
    check2("reset_level_single", level_b, 2'b00);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // btn0 press + repeats, release, both-pressed, DB-length glitch, DB+1 press
    vq.push_back('{2'b10,  6, 2'b00, 2'b00, 2'b00, 2'b00});
    vq.push_back('{2'b10,  1, 2'b01, 2'b01, 2'b01, 2'b01});
    vq.push_back('{2'b10,  1, 2'b00, 2'b01, 2'b00, 2'b01});
    vq.push_back('{2'b10, 18, 2'b00, 2'b01, 2'b00, 2'b01});
    vq.push_back('{2'b10,  1, 2'b01, 2'b01, 2'b00, 2'b01});
    vq.push_back('{2'b10,  7, 2'b00, 2'b01, 2'b00, 2'b01});
    vq.push_back('{2'b10,  1, 2'b01, 2'b01, 2'b00, 2'b01});
    vq.push_back('{2'b10,  7, 2'b00, 2'b01, 2'b00, 2'b01});
    vq.push_back('{2'b10,  1, 2'b01, 2'b01, 2'b00, 2'b01});
    vq.push_back('{2'b10,  7, 2'b00, 2'b01, 2'b00, 2'b01});
    vq.push_back('{2'b10,  1, 2'b01, 2'b01, 2'b00, 2'b01});
    vq.push_back('{2'b10,  7, 2'b00, 2'b01, 2'b00, 2'b01});
    vq.push_back('{2'b10,  1, 2'b01, 2'b01, 2'b00, 2'b01});
    vq.push_back('{2'b10,  1, 2'b00, 2'b01, 2'b00, 2'b01});
    vq.push_back('{2'b11,  6, 2'b00, 2'b01, 2'b00, 2'b01});
    vq.push_back('{2'b11,  1, 2'b00, 2'b00, 2'b00, 2'b00});
    vq.push_back('{2'b11,  4, 2'b00, 2'b00, 2'b00, 2'b00});
    vq.push_back('{2'b00,  6, 2'b00, 2'b00, 2'b00, 2'b00});
    vq.push_back('{2'b00,  1, 2'b11, 2'b11, 2'b11, 2'b11});
    vq.push_back('{2'b00,  1, 2'b00, 2'b11, 2'b00, 2'b11});
    vq.push_back('{2'b11,  6, 2'b00, 2'b11, 2'b00, 2'b11});
    vq.push_back('{2'b11,  1, 2'b00, 2'b00, 2'b00, 2'b00});
    vq.push_back('{2'b10,  4, 2'b00, 2'b00, 2'b00, 2'b00});
    vq.push_back('{2'b11,  8, 2'b00, 2'b00, 2'b00, 2'b00});
    vq.push_back('{2'b10,  5, 2'b00, 2'b00, 2'b00, 2'b00});
    vq.push_back('{2'b11,  1, 2'b00, 2'b00, 2'b00, 2'b00});
    vq.push_back('{2'b11,  1, 2'b01, 2'b01, 2'b01, 2'b01});
    vq.push_back('{2'b11,  4, 2'b00, 2'b01, 2'b00, 2'b01});
    vq.push_back('{2'b11,  1, 2'b00, 2'b00, 2'b00, 2'b00});
    vq.push_back('{2'b11,  4, 2'b00, 2'b00, 2'b00, 2'b00});

    for (int i = 0; i < vq.size(); i++) begin
      push = vq[i].push;
      repeat (vq[i].n_edges) step();
      check2($sformatf("vec%0d_pulse_rpt", i), pulse_a, vq[i].pulse_a);
      check2($sformatf("vec%0d_level_rpt", i), level_a, vq[i].level_a);
      check2($sformatf("vec%0d_pulse_single", i), pulse_b, vq[i].pulse_b);
      check2($sformatf("vec%0d_level_single", i), level_b, vq[i].level_b);
    end

    // 3-cycle low glitch on btn1
    seen_p = 1'b0; seen_l = 1'b0;
    push = 2'b01;
    repeat (3) begin step(); seen_p |= pulse_a[1] | pulse_b[1]; seen_l |= level_a[1] | level_b[1]; end
    push = 2'b11;
    repeat (10) begin step(); seen_p |= pulse_a[1] | pulse_b[1]; seen_l |= level_a[1] | level_b[1]; end
    check_int("glitch_pulse", int'(seen_p), 0);
    check_int("glitch_level", int'(seen_l), 0);

    // 100-edge hold: single instance pulses once, repeating instance 11 times
    cnt_a = 0; cnt_b = 0; first_b = 0;
    push = 2'b10;
    for (int k = 1; k <= 100; k++) begin
      step();
      if (pulse_a[0]) cnt_a++;
      if (pulse_b[0]) begin cnt_b++; if (first_b == 0) first_b = k; end
    end
    check_int("hold100_single_count", cnt_b, 1);
    check_int("hold100_single_edge", first_b, 7);
    check_int("hold100_rpt_count", cnt_a, 11);
    push = 2'b11;
    repeat (12) step();

    // reset during a held press
    push = 2'b10;
    repeat (14) step();
    check2("pre_reset_level", level_a, 2'b01);
    rst_n = 1'b0;
    model_reset();
    #1;
    check2("in_reset_pulse", pulse_a | pulse_b, 2'b00);
    check2("in_reset_level", level_a | level_b, 2'b00);
    repeat (5) step();
    rst_n = 1'b1;
    e = 0; got = 1'b0;
    while (!got && e < 20) begin
      step(); e++;
      if (pulse_a[0]) got = 1'b1;
    end
    check_int("post_reset_press_edge", e, 7);
    push = 2'b11;
    repeat (12) step();

    // 2-cycle release bounce during hold restarts the repeat delay
    cnt_a = 0; lvl_drop = 1'b0;
    push = 2'b10;
    repeat (11) step();
    push = 2'b11;
    repeat (2) begin step(); cnt_a += int'(pulse_a[0]); lvl_drop |= ~level_a[0]; end
    push = 2'b10;
    e = 13; got = 1'b0;
    while (!got && e < 60) begin
      step(); e++;
      if (pulse_a[0]) got = 1'b1;
      else cnt_a += 0;
      lvl_drop |= ~level_a[0];
    end
    check_int("bounce_repeat_edge", e, 36);
    check_int("bounce_no_pulse", cnt_a, 0);
    check_int("bounce_level_held", int'(lvl_drop), 0);
    push = 2'b11;
    repeat (12) step();

    // random press patterns with occasional resets
    val[0] = 1'b1; val[1] = 1'b1; left[0] = 0; left[1] = 0;
    for (int r = 0; r < 3000; r++) begin
      for (int c = 0; c < 2; c++) begin
        if (left[c] == 0) begin
          val[c] = ~val[c];
          left[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 60))
                                                : int'($urandom_range(1, 7));
        end
        left[c]--;
      end
      push = {val[1], val[0]};
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(0, 599) == 0) begin
        rst_n = 1'b0;
        model_reset();
      end
      step();
    end
    rst_n = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
